// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between the instruction cache and decode.
// Each accepted fetch word carries two 32-bit instructions. An aligned word
// (in_pc[2]=0) enqueues both. An unaligned word enqueues only the upper
// instruction. Decode sees the two oldest entries combinationally and consumes
// 0..2 of them per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   flush      discard all queued entries at the next edge
//   in_valid   fetch word present
//   in_pc      fetch word address (bits [1:0] are zero)
//   in_data    {instr at pc|4, instr at pc&~4}
//   in_ready   room for a full two-instruction word (count <= DEPTH-2)
//   out_valid  [0]: head present, [1]: head+1 present
//   out_instr0/out_pc0  head entry
//   out_instr1/out_pc1  head+1 entry
//   deq_cnt    entries consumed this cycle (clamped to count)
//   count      occupied entries
module fetch_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [63:0]              in_data,
    output logic                     in_ready,
    output logic [1:0]               out_valid,
    output logic [31:0]              out_instr0,
    output logic [31:0]              out_instr1,
    output logic [31:0]              out_pc0,
    output logic [31:0]              out_pc1,
    input  logic [1:0]               deq_cnt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two and at least 4");
    end

    // Storage is deliberately left without reset.
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;
    logic          push_en;
    logic          push_two;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    logic [CW-1:0] deq_ext;

    always_comb begin
        deq_ext  = CW'(deq_cnt);
        head_p1  = head + PW'(1);
        tail_p1  = tail + PW'(1);
        // Ready is a pure function of registered count so that upstream
        // never sees a combinational path from deq_cnt or flush.
        in_ready = (count <= CW'(DEPTH - 2));
        push_en  = in_valid & in_ready & ~flush;
        push_two = ~in_pc[2];
        push_n   = '0;
        if (push_en) begin
            push_n = push_two ? 2'd2 : 2'd1;
        end
        // Over-consumption is clamped; deq_cnt > count implies count < 3,
        // so the low two bits of count hold its full value.
        pop_n = '0;
        if (!flush) begin
            if (deq_ext > count) begin
                pop_n = count[1:0];
            end else begin
                pop_n = deq_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_n);
            tail  <= tail + PW'(push_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    // Second slot of an aligned push wraps naturally through tail_p1.
    always_ff @(posedge clk) begin
        if (push_en) begin
            if (push_two) begin
                pc_mem[tail]     <= in_pc;
                instr_mem[tail]  <= in_data[31:0];
                pc_mem[tail_p1]    <= in_pc + 32'd4;
                instr_mem[tail_p1] <= in_data[63:32];
            end else begin
                pc_mem[tail]     <= in_pc;
                instr_mem[tail]  <= in_data[63:32];
            end
        end
    end

    always_comb begin
        out_valid[0] = (count != '0);
        out_valid[1] = (count >= CW'(2));
        out_pc0      = pc_mem[head];
        out_instr0   = instr_mem[head];
        out_pc1      = pc_mem[head_p1];
        out_instr1   = instr_mem[head_p1];
    end

    a_deq_le_count: assert property (@(posedge clk) disable iff (rst) deq_ext <= count)
        else $error("fetch_queue: deq_cnt exceeds count");

    a_count_le_depth: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH))
        else $error("fetch_queue: count exceeds DEPTH");

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: scoreboard of expected {pc, instr} entries in
// queue order; scenario tasks compare the DUT outputs against it and against
// fixed constants.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [63:0] in_data;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [31:0] out_instr0;
    logic [31:0] out_instr1;
    logic [31:0] out_pc0;
    logic [31:0] out_pc1;
    logic [1:0]  deq_cnt;
    logic [3:0]  count;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [63:0] sb[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_instr0 (out_instr0),
        .out_instr1 (out_instr1),
        .out_pc0    (out_pc0),
        .out_pc1    (out_pc1),
        .deq_cnt    (deq_cnt),
        .count      (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one cycle of stimulus and updates the scoreboard with the
    // architectural effect expected at the coming edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [63:0] d,
                        input logic [1:0] dq, input logic fl);
        int sz;
        int n;
        bit rdy;
        in_valid = v;
        in_pc    = pc;
        in_data  = d;
        deq_cnt  = dq;
        flush    = fl;
        if (fl) begin
            sb.delete();
        end else begin
            sz  = sb.size();
            rdy = (sz <= int'(DEPTH) - 2);
            n   = (int'(dq) > sz) ? sz : int'(dq);
            repeat (n) void'(sb.pop_front());
            if (v && rdy) begin
                if (!pc[2]) begin
                    sb.push_back({pc, d[31:0]});
                    sb.push_back({pc + 32'd4, d[63:32]});
                end else begin
                    sb.push_back({pc, d[63:32]});
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        deq_cnt  = 2'd0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drain();
        int sz;
        for (int k = 0; k < int'(DEPTH) && sb.size() > 0; k++) begin
            vectors++;
            if ({out_pc0, out_instr0} !== sb[0]) begin
                miscompares++;
                $display("FAIL drain_head: got %h_%h want %h", out_pc0, out_instr0, sb[0]);
            end
            sz = sb.size();
            step(1'b0, 32'h0, 64'h0, (sz >= 2) ? 2'd2 : 2'd1, 1'b0);
        end
        vectors++;
        if (count !== 4'd0) begin
            miscompares++;
            $display("FAIL drain_count: got %0d want 0", count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d want 0", count);
        end
        vectors++;
        if (out_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 00", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_aligned_push();
        do_reset();
        in_valid = 1'b1;
        in_pc    = 32'h1000;
        in_data  = 64'h22222222_11111111;
        #1;
        vectors++;
        if (out_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL no_bypass: got %b want 00", out_valid);
        end
        step(1'b1, 32'h1000, 64'h22222222_11111111, 2'd0, 1'b0);
        vectors++;
        if (out_valid !== 2'b11) begin
            miscompares++;
            $display("FAIL aligned_valid: got %b want 11", out_valid);
        end
        vectors++;
        if ({out_pc0, out_instr0} !== 64'h00001000_11111111) begin
            miscompares++;
            $display("FAIL aligned_head0: got %h_%h want 00001000_11111111", out_pc0, out_instr0);
        end
        vectors++;
        if ({out_pc1, out_instr1} !== 64'h00001004_22222222) begin
            miscompares++;
            $display("FAIL aligned_head1: got %h_%h want 00001004_22222222", out_pc1, out_instr1);
        end
        vectors++;
        if (count !== 4'd2) begin
            miscompares++;
            $display("FAIL aligned_count: got %0d want 2", count);
        end
        drain();
    endtask

    task automatic test_unaligned_push();
        step(1'b1, 32'h2004, 64'hAAAAAAAA_BBBBBBBB, 2'd0, 1'b0);
        vectors++;
        if (count !== 4'd1 || out_valid !== 2'b01) begin
            miscompares++;
            $display("FAIL unaligned_count_valid: got %0d/%b want 1/01", count, out_valid);
        end
        vectors++;
        if ({out_pc0, out_instr0} !== 64'h00002004_AAAAAAAA) begin
            miscompares++;
            $display("FAIL unaligned_head0: got %h_%h want 00002004_AAAAAAAA", out_pc0, out_instr0);
        end
        drain();
    endtask

    task automatic test_full();
        do_reset();
        step(1'b1, 32'h100, 64'h0000_0101_0000_0100, 2'd0, 1'b0);
        step(1'b1, 32'h108, 64'h0000_0109_0000_0108, 2'd0, 1'b0);
        step(1'b1, 32'h110, 64'h0000_0111_0000_0110, 2'd0, 1'b0);
        vectors++;
        if (in_ready !== 1'b1 || count !== 4'd6) begin
            miscompares++;
            $display("FAIL full_at6: got ready=%b count=%0d want 1/6", in_ready, count);
        end
        step(1'b1, 32'h11C, 64'h0000_011D_0000_011C, 2'd0, 1'b0);
        vectors++;
        if (in_ready !== 1'b0 || count !== 4'd7) begin
            miscompares++;
            $display("FAIL full_at7: got ready=%b count=%0d want 0/7", in_ready, count);
        end
        step(1'b1, 32'h120, 64'h0000_0121_0000_0120, 2'd0, 1'b0);
        vectors++;
        if (count !== 4'd7) begin
            miscompares++;
            $display("FAIL full_drop: got %0d want 7", count);
        end
        step(1'b1, 32'h128, 64'h0000_0129_0000_0128, 2'd2, 1'b0);
        vectors++;
        if (count !== 4'd5 || out_pc0 !== 32'h108) begin
            miscompares++;
            $display("FAIL full_deq_while_full: got count=%0d pc0=%h want 5/00000108", count, out_pc0);
        end
        step(1'b1, 32'h124, 64'h0000_0125_0000_0124, 2'd0, 1'b0);
        step(1'b1, 32'h130, 64'h0000_0131_0000_0130, 2'd0, 1'b0);
        vectors++;
        if (in_ready !== 1'b0 || count !== 4'd8 || out_valid !== 2'b11) begin
            miscompares++;
            $display("FAIL full_at8: got ready=%b count=%0d valid=%b want 0/8/11", in_ready, count, out_valid);
        end
        drain();
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b1, 32'h4000, 64'h1, 2'd0, 1'b0);
        step(1'b1, 32'h4008, 64'h2, 2'd0, 1'b0);
        step(1'b1, 32'h4010, 64'h3, 2'd0, 1'b0);
        drain();
        step(1'b1, 32'h5004, 64'h5005_0000_5004_0000, 2'd0, 1'b0);
        step(1'b1, 32'h5008, 64'h500C_0000_5008_0000, 2'd0, 1'b0);
        vectors++;
        if (count !== 4'd3 || out_pc0 !== 32'h5004 || out_instr0 !== 32'h5005_0000
            || out_pc1 !== 32'h5008 || out_instr1 !== 32'h5008_0000) begin
            miscompares++;
            $display("FAIL wrap_write: got count=%0d %h_%h %h_%h", count, out_pc0, out_instr0, out_pc1, out_instr1);
        end
        step(1'b1, 32'h5010, 64'h5014_0000_5010_0000, 2'd2, 1'b0);
        vectors++;
        if (count !== 4'd3 || out_pc0 !== 32'h500C || out_instr0 !== 32'h500C_0000
            || out_pc1 !== 32'h5010) begin
            miscompares++;
            $display("FAIL wrap_push_pop: got count=%0d pc0=%h instr0=%h pc1=%h want 3/500c/500c0000/5010",
                     count, out_pc0, out_instr0, out_pc1);
        end
        drain();
    endtask

    task automatic test_flush();
        do_reset();
        step(1'b1, 32'h6000, 64'h1, 2'd0, 1'b0);
        step(1'b1, 32'h6008, 64'h2, 2'd0, 1'b0);
        step(1'b1, 32'h6010, 64'h3, 2'd0, 1'b0);
        step(1'b1, 32'h6018, 64'h4, 2'd1, 1'b1);
        vectors++;
        if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_state: got count=%0d valid=%b ready=%b want 0/00/1", count, out_valid, in_ready);
        end
        step(1'b1, 32'h3000, 64'h3004_3004_3000_3000, 2'd0, 1'b0);
        vectors++;
        if (count !== 4'd2 || {out_pc0, out_instr0} !== 64'h00003000_30003000) begin
            miscompares++;
            $display("FAIL flush_repush: got count=%0d %h_%h want 2/00003000_30003000", count, out_pc0, out_instr0);
        end
        drain();
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 32'h6800, 64'h1, 2'd0, 1'b0);
        step(1'b1, 32'h6808, 64'h2, 2'd0, 1'b0);
        vectors++;
        if (count !== 4'd4) begin
            miscompares++;
            $display("FAIL async_pre: got %0d want 4", count);
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got count=%0d valid=%b ready=%b want 0/00/1", count, out_valid, in_ready);
        end
        #1;
        rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        step(1'b1, 32'h7000, 64'h7004_0000_7000_0000, 2'd0, 1'b0);
        vectors++;
        if (count !== 4'd2 || out_pc0 !== 32'h7000 || out_pc1 !== 32'h7004) begin
            miscompares++;
            $display("FAIL async_repush: got count=%0d pc0=%h pc1=%h want 2/7000/7004", count, out_pc0, out_pc1);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int          sz;
        int          mx;
        logic [31:0] pc;
        logic [1:0]  vexp;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            sz = sb.size();
            mx = (sz > 2) ? 2 : sz;
            pc = 32'h8000 + 32'(i * 8) + ($urandom_range(0, 1) != 0 ? 32'd4 : 32'd0);
            step(1'($urandom_range(0, 3) != 0), pc, {$urandom, $urandom},
                 2'($urandom_range(0, mx)), 1'($urandom_range(0, 19) == 0));
            sz   = sb.size();
            vexp = {sz >= 2, sz >= 1};
            vectors++;
            if (count !== 4'(sz) || out_valid !== vexp || in_ready !== (sz <= int'(DEPTH) - 2)) begin
                miscompares++;
                $display("FAIL b2b_state[%0d]: got count=%0d valid=%b ready=%b want %0d/%b", i, count, out_valid, in_ready, sz, vexp);
            end
            if (sz >= 1) begin
                vectors++;
                if ({out_pc0, out_instr0} !== sb[0]) begin
                    miscompares++;
                    $display("FAIL b2b_head0[%0d]: got %h_%h want %h", i, out_pc0, out_instr0, sb[0]);
                end
            end
            if (sz >= 2) begin
                vectors++;
                if ({out_pc1, out_instr1} !== sb[1]) begin
                    miscompares++;
                    $display("FAIL b2b_head1[%0d]: got %h_%h want %h", i, out_pc1, out_instr1, sb[1]);
                end
            end
        end
        drain();
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_pc    = '0;
        in_data  = '0;
        deq_cnt  = '0;
        test_reset();
        test_aligned_push();
        test_unaligned_push();
        test_full();
        test_wrap();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
